fifo_wr_arbiter: RTL and testbench

Round-robin arbiter sharing the single write port of the async FIFO among `NUM_REQ` write-domain requesters. It sits in the `wclk` domain, directly in front of the FIFO write-pointer/full logic. It drives `winc` and `wdata` from the granted requester and back-pressures every requester on `full`. An optional burst lock holds a grant for up to `BURST_LEN` consecutive words so that packets are not interleaved in the FIFO.

---
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_BURST_LOCK_EN to hold a grant for up to BURST_LEN words.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          wclk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
`endif

    logic [PTR_W-1:0]       sel_idx;
    logic                   sel_found;
    logic                   g_valid;
    logic                   xfer;
    logic                   last_beat;
    logic [PTR_W-1:0]       next_ptr;
    logic [DATA_WIDTH-1:0]  masked_data [NUM_REQ];

    // One-hot AND-OR data mux: zero when nothing is granted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                     & {DATA_WIDTH{grant_q[gi]}};
        end
    endgenerate

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wdata = wdata | masked_data[i];
        end
    end

    assign req_ready = grant_q & {NUM_REQ{~full}};
    assign g_valid   = |(grant_q & req_valid);
    assign xfer      = g_valid & ~full;
    assign winc      = xfer;
    assign grant     = grant_q;
    assign busy      = (state_q == GRANT);
    assign next_ptr  = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
`else
    assign last_beat = 1'b1;
`endif

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
        beat_cnt_d = beat_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = GRANT;
                    grant_d = NUM_REQ'(1) << sel_idx;
                    gidx_d  = sel_idx;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
                    beat_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                // A full stall neither releases nor advances the beat count.
                if (!g_valid || (xfer && last_beat)) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
                else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
            beat_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences
// and randomized traffic against a behavioural grant/burst model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    localparam int LIMIT = BL;
`else
    localparam int LIMIT = 1;
`endif
    localparam logic [31:0] TBL_DATA = 32'h3322_1100;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            full;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [N-1:0]    grant;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .BURST_LEN (BL)
    ) dut (
        .wclk     (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .full     (full),
        .winc     (winc),
        .wdata    (wdata),
        .grant    (grant),
        .busy     (busy)
    );

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    logic [7:0] wq [$];

    // Model: current owner (-1 idle), words written in this grant, next search start.
    int m_owner = -1;
    int m_words = 0;
    int m_next  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h (t=%0t)", phase, name, act, exp, $time);
        end
    endtask

    function automatic void model_edge(logic r, logic [N-1:0] v, logic f);
        if (r) begin
            m_owner = -1;
            m_words = 0;
            m_next  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_next + k) % N;
                if (v[i]) begin
                    m_owner = i;
                    m_words = 0;
                    break;
                end
            end
        end else if (!v[m_owner]) begin
            m_next  = (m_owner + 1) % N;
            m_owner = -1;
        end else if (!f) begin
            m_words++;
            if (m_words == LIMIT) begin
                m_next  = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endfunction

    // Apply inputs mid-cycle and compare every output against the model.
    task automatic drive(logic r, logic [N-1:0] v, logic f, logic [31:0] d);
        logic [N-1:0] eg;
        logic         ew;
        logic [7:0]   ed;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        full      = f;
        req_data  = d;
        #1;
        eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
        ew = (m_owner < 0) ? 1'b0 : (v[m_owner] & ~f);
        ed = (m_owner < 0) ? 8'h00 : d[m_owner*8 +: 8];
        check("grant", 32'(grant), 32'(eg));
        check("req_ready", 32'(req_ready), f ? 32'd0 : 32'(eg));
        check("winc", 32'(winc), 32'(ew));
        check("wdata", 32'(wdata), 32'(ed));
        check("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        $display("%s: rst=%b valid=%b full=%b grant=%b winc=%b wdata=%h", phase, r, v, f, grant, winc, wdata);
        if (winc === 1'b1) wq.push_back(wdata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst, req_valid, full);
    endtask

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [3:0] g;
        logic [3:0] rdy;
        logic       w;
        logic [7:0] wd;
    } vec_t;

    vec_t vt [$];

    function automatic void add(logic r, logic [3:0] v, logic [3:0] g, logic [3:0] rdy,
                                logic w, logic [7:0] wd);
        vec_t e;
        e.r = r; e.v = v; e.g = g; e.rdy = rdy; e.w = w; e.wd = wd;
        vt.push_back(e);
    endfunction

    function automatic logic [7:0] rr_word(int j);
        int b;
        b = j / LIMIT;
        return 8'((b % N) * 16 + (b / N) * LIMIT + (j % LIMIT));
    endfunction

    initial begin
        int n;
        int cnt [N];
        logic [31:0] d;
        rst = 1'b1; req_valid = '0; full = 1'b0; req_data = '0;

        // Reset hold, then early release of req0/req1 steering rr_ptr to 2,
        // then req2 drops valid after one word while req1 waits.
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 8'h00);
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 8'h00);
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b1111, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b0000, 4'b0001, 4'b0001, 0, 8'h00);
        add(0, 4'b0010, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b0000, 4'b0010, 4'b0010, 0, 8'h11);
        add(0, 4'b0110, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b0110, 4'b0100, 4'b0100, 1, 8'h22);
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
        add(0, 4'b0010, 4'b0100, 4'b0100, 0, 8'h22);
        add(0, 4'b0010, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b0000, 4'b0010, 4'b0010, 0, 8'h11);
`else
        add(0, 4'b0010, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b0000, 4'b0010, 4'b0010, 0, 8'h11);
`endif
        phase = "table";
        foreach (vt[i]) begin
            drive(vt[i].r, vt[i].v, 1'b0, TBL_DATA);
            check("tbl_grant", 32'(grant), 32'(vt[i].g));
            check("tbl_ready", 32'(req_ready), 32'(vt[i].rdy));
            check("tbl_winc", 32'(winc), 32'(vt[i].w));
            check("tbl_wdata", 32'(wdata), 32'(vt[i].wd));
            tick();
        end

        // Round robin with all requesters valid; requester i sends i*16+k.
        phase = "round_robin";
        drive(1'b1, '0, 1'b0, '0); tick();
        drive(1'b1, '0, 1'b0, '0); tick();
        foreach (cnt[i]) cnt[i] = 0;
        wq.delete();
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) d[i*8 +: 8] = 8'(i * 16 + cnt[i]);
            drive(1'b0, 4'hF, 1'b0, d);
            for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) cnt[i]++;
            tick();
        end
        check("rr_count", wq.size(), 32'(40 * LIMIT / (LIMIT + 1)));
        for (int j = 0; j < wq.size() && j < 40 * LIMIT / (LIMIT + 1); j++)
            check("rr_order", 32'(wq[j]), 32'(rr_word(j)));

        // Full stall mid-grant on req0.
        phase = "full_stall";
        drive(1'b1, '0, 1'b0, '0); tick();
        wq.delete();
        n = 0;
        while (!(wq.size() >= ((LIMIT > 1) ? 2 : 1) && m_owner == 0) && n < 20) begin
            drive(1'b0, 4'b0001, 1'b0, 32'h0000_00A5); tick(); n++;
        end
        check("setup_bound", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0001, 1'b1, 32'h0000_00A5);
            check("stall_grant", 32'(grant), 32'd1);
            check("stall_winc", 32'(winc), 32'd0);
            check("stall_ready0", 32'(req_ready[0]), 32'd0);
            tick();
        end
        wq.delete();
        n = 0;
        while (m_owner == 0 && n < 20) begin
            drive(1'b0, 4'b0001, 1'b0, 32'h0000_00A5); tick(); n++;
        end
        check("post_words", wq.size(), (LIMIT > 1) ? 32'(LIMIT - 2) : 32'd1);
        drive(1'b0, 4'b0000, 1'b0, 32'h0000_00A5);
        check("released", 32'(grant), 32'd0);
        tick();

        // Reset after req3's second word.
        phase = "reset_mid";
        drive(1'b1, '0, 1'b0, '0); tick();
        wq.delete();
        n = 0;
        while (wq.size() < 2 && n < 20) begin
            drive(1'b0, 4'b1000, 1'b0, 32'h3300_0000); tick(); n++;
        end
        check("req3_bound", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        drive(1'b1, 4'hF, 1'b0, TBL_DATA); tick();
        drive(1'b0, 4'hF, 1'b0, TBL_DATA);
        check("grant_after_rst", 32'(grant), 32'd0);
        tick();
        drive(1'b0, 4'hF, 1'b0, TBL_DATA);
        check("req0_wins", 32'(grant), 32'd1);
        tick();

        // Randomized traffic against the model.
        phase = "random";
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 4) == 0), $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
